// File: rtl/decode_pkg.sv
// Shared opcode constants, field positions and decoded-field types for the
// fetch-to-decode stage of the 5-bit-opcode, 32-bit-instruction core.
package decode_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;

  localparam int FIELD_W    = 5;
  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_LSB  = 2;
  localparam int IMM_MSB    = 16;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [31:0] immediate;
    logic        we;
    logic        mwen;
    logic        lw;
  } decoded_t;

  typedef struct packed {
    logic rd;
    logic rs;
    logic rt;
  } read_set_t;

endpackage

// File: rtl/insn_field_decode.sv
// Purely combinational split of one instruction word into fields, write
// controls and the set of source registers the instruction reads.
module insn_field_decode
  import decode_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [31:0]       ins_i,
  output decoded_t          fields_o,
  output read_set_t         reads_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [4:0] op;
  assign op       = ins_i[OPCODE_LSB +: FIELD_W];
  assign target_o = ins_i[ADDR_W-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value held (latch).
  always_comb begin
    fields_o           = '0;
    reads_o            = '0;
    fields_o.opcode    = op;
    fields_o.rd        = ins_i[RD_LSB    +: FIELD_W];
    fields_o.rs        = ins_i[RS_LSB    +: FIELD_W];
    fields_o.rt        = ins_i[RT_LSB    +: FIELD_W];
    fields_o.shamt     = ins_i[SHAMT_LSB +: FIELD_W];
    fields_o.aluop     = ins_i[ALUOP_LSB +: FIELD_W];
    fields_o.immediate = {{(31 - IMM_MSB){ins_i[IMM_MSB]}}, ins_i[IMM_MSB:0]};
    fields_o.we        = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW) ||
                         (op == OP_JAL) || (op == OP_SETX);
    fields_o.mwen      = (op == OP_SW);
    fields_o.lw        = (op == OP_LW);
    case (op)
      OP_ADD:                begin reads_o.rs = 1'b1; reads_o.rt = 1'b1; end
      OP_ADDI, OP_LW:        reads_o.rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin reads_o.rd = 1'b1; reads_o.rs = 1'b1; end
      OP_JR:                 reads_o.rd = 1'b1;
      default:               ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode stage: DEPTH-entry {pc, instruction} FIFO with fall-through,
// registered decoded output, one-bubble load-use interlock, flush, stall count.
module decode_queue
  import decode_pkg::*;
#(
  parameter  int ADDR_W = 12,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int OCC_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic [31:0]       in_ins_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [4:0]        out_opcode_o,
  output logic [4:0]        out_rd_o,
  output logic [4:0]        out_rs_o,
  output logic [4:0]        out_rt_o,
  output logic [4:0]        out_shamt_o,
  output logic [4:0]        out_aluop_o,
  output logic [31:0]       out_immediate_o,
  output logic [ADDR_W-1:0] out_target_o,
  output logic              out_we_o,
  output logic              out_mwen_o,
  output logic              out_lw_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [31:0]       ins_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              out_valid_q, out_valid_d;
  decoded_t          out_q;
  logic [ADDR_W-1:0] out_pc_q, out_target_q;

  logic              fifo_empty, push, consume, head_valid, hazard, load;
  logic              fifo_push, fifo_pop, head_match;
  logic [ADDR_W-1:0] head_pc, head_target;
  logic [31:0]       head_ins;
  decoded_t          head_fields;
  read_set_t         head_reads;

  assign fifo_empty = (count_q == '0);
  assign in_ready_o = (count_q < OCC_W'(DEPTH));
  assign push       = in_valid_i && in_ready_o && !flush_i;
  assign consume    = out_valid_q && out_ready_i && !flush_i;

  // With the FIFO empty, a word being pushed is the head and may load directly.
  assign head_valid = !fifo_empty || push;
  assign head_pc    = fifo_empty ? in_pc_i  : pc_mem[rd_ptr_q];
  assign head_ins   = fifo_empty ? in_ins_i : ins_mem[rd_ptr_q];

  insn_field_decode #(.ADDR_W(ADDR_W)) u_head_decode (
    .ins_i    (head_ins),
    .fields_o (head_fields),
    .reads_o  (head_reads),
    .target_o (head_target)
  );

  assign head_match = (head_reads.rd && head_fields.rd == out_q.rd) ||
                      (head_reads.rs && head_fields.rs == out_q.rs) ||
                      (head_reads.rt && head_fields.rt == out_q.rd) ||
                      (head_reads.rs && head_fields.rs == out_q.rd);
  assign hazard = consume && out_q.lw && (out_q.rd != '0) && head_valid &&
                  ((head_reads.rd && head_fields.rd == out_q.rd) ||
                   (head_reads.rs && head_fields.rs == out_q.rd) ||
                   (head_reads.rt && head_fields.rt == out_q.rd));
  assign load   = !flush_i && head_valid && (!out_valid_q || out_ready_i) && !hazard;

  assign fifo_push = push && !(fifo_empty && load);
  assign fifo_pop  = load && !fifo_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_d     = stall_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + OCC_W'(fifo_push) - OCC_W'(fifo_pop);
      if (load)         out_valid_d = 1'b1;
      else if (consume) out_valid_d = 1'b0;
    end
    if (hazard && stall_q != '1) stall_d = stall_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stall_q      <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_pc_q     <= '0;
      out_target_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        out_q        <= head_fields;
        out_pc_q     <= head_pc;
        out_target_q <= head_target;
      end
    end
  end

  // NOTE: storage is not reset; an entry is only read after it is written,
  // and leaving it out of reset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      pc_mem[wr_ptr_q]  <= in_pc_i;
      ins_mem[wr_ptr_q] <= in_ins_i;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_pc_o        = out_pc_q;
  assign out_opcode_o    = out_q.opcode;
  assign out_rd_o        = out_q.rd;
  assign out_rs_o        = out_q.rs;
  assign out_rt_o        = out_q.rt;
  assign out_shamt_o     = out_q.shamt;
  assign out_aluop_o     = out_q.aluop;
  assign out_immediate_o = out_q.immediate;
  assign out_target_o    = out_target_q;
  assign out_we_o        = out_q.we;
  assign out_mwen_o      = out_q.mwen;
  assign out_lw_o        = out_q.lw;
  assign occupancy_o     = count_q;
  assign stall_count_o   = stall_q;

endmodule
